pong_anim_graph: RTL and testbench



---
 rtl/pong_pkg.sv | 10 +
 rtl/pong_paddle_ctrl.sv | 35 +++
 rtl/pong_anim_graph.sv | 142 ++++++++++++++
 tb/tb_pong_anim_graph.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: colours and FSM state encodings shared by the animated Pong renderer.
package pong_pkg;
    localparam logic [11:0] WALL_RGB  = 12'hF00;
    localparam logic [11:0] PAD_RGB   = 12'h0F0;
    localparam logic [11:0] BALL_RGB  = 12'h00F;
    localparam logic [11:0] HWALL_RGB = 12'h00F;
    localparam logic [11:0] BG_RGB    = 12'hFF0;
    localparam logic SERVE = 1'b0;
    localparam logic PLAY  = 1'b1;
endpackage

// File: rtl/pong_paddle_ctrl.sv
// pong_paddle_ctrl: once-per-frame paddle movement, clamped between the top and bottom walls.
module pong_paddle_ctrl #(
    parameter int V_ACTIVE = 480,
    parameter int WALL_T   = 6,
    parameter int PAD_H    = 72,
    parameter int PAD_V    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [9:0] pad_y
);
    localparam logic [9:0] Y_MIN = 10'(WALL_T);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - WALL_T - PAD_H);
    localparam logic [9:0] Y_RST = 10'((V_ACTIVE - PAD_H) / 2);
    localparam logic [9:0] STEP  = 10'(PAD_V);

    logic [9:0] pad_y_q, pad_y_d;

    always_comb begin
        pad_y_d = pad_y_q;
        if (tick && btn_up && !btn_dn)
            pad_y_d = (pad_y_q < Y_MIN + STEP) ? Y_MIN : pad_y_q - STEP;
        else if (tick && btn_dn && !btn_up)
            pad_y_d = (pad_y_q + STEP > Y_MAX) ? Y_MAX : pad_y_q + STEP;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) pad_y_q <= Y_RST;
        else          pad_y_q <= pad_y_d;

    assign pad_y = pad_y_q;
endmodule

// File: rtl/pong_anim_graph.sv
// pong_anim_graph: animated Pong object renderer; ball/paddle state advances once per frame
// during vertical blanking and the pixel colour is registered for the VGA output stage.
module pong_anim_graph
    import pong_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int WALL_T       = 6,
    parameter int LWALL_L      = 32,
    parameter int LWALL_R      = 35,
    parameter int PAD_L        = 600,
    parameter int PAD_W        = 4,
    parameter int PAD_H        = 72,
    parameter int PAD_V        = 4,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_V       = 2,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        btn_up,
    input  logic        btn_dn,
    output logic [11:0] rgb,
    output logic        hit,
    output logic        miss
);
    localparam int CW = $clog2(SERVE_FRAMES);
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [9:0]  BX0   = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  BY0   = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  V     = 10'(BALL_V);
    localparam logic [9:0]  Y_MIN = 10'(WALL_T);
    localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - WALL_T - BALL_SIZE);
    localparam logic [9:0]  X_MIN = 10'(LWALL_R + 1);
    localparam logic [9:0]  X_HIT = 10'(PAD_L - BALL_SIZE);

    logic [11:0] rgb_q, rgb_d;
    logic        hit_q, hit_d, miss_q, miss_d, cond_q;
    logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d, pad_y;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d, state_q, state_d;
    logic [CW-1:0] serve_cnt_q, serve_cnt_d;
    logic [10:0] bx, by, py, px, pyy;
    logic        cond, tick, mv, top_c, bot_c, left_c, hit_c, miss_c;
    logic        in_lw, in_pad, in_ball, in_hw;

    assign cond = (pixel_x == '0) && (pixel_y == 10'(V_ACTIVE));
    assign tick = cond && !cond_q;
    assign mv   = tick && (state_q == PLAY);

    // all bounds are compared at 11 bits so the additions cannot wrap
    assign bx  = {1'b0, ball_x_q};
    assign by  = {1'b0, ball_y_q};
    assign py  = {1'b0, pad_y};
    assign px  = {1'b0, pixel_x};
    assign pyy = {1'b0, pixel_y};

    assign top_c  = !dir_y_q && by < 11'(WALL_T + BALL_V);
    assign bot_c  = dir_y_q && by + 11'(BALL_SIZE + BALL_V) > 11'(V_ACTIVE - WALL_T);
    assign left_c = !dir_x_q && bx < 11'(LWALL_R + 1 + BALL_V);
    assign hit_c  = dir_x_q && bx + 11'(BALL_SIZE - 1 + BALL_V) >= 11'(PAD_L)
                 && bx <= 11'(PAD_L + PAD_W - 1)
                 && by + 11'(BALL_SIZE - 1) >= py && by <= py + 11'(PAD_H - 1);
    assign miss_c = dir_x_q && !hit_c && bx + 11'(BALL_SIZE + BALL_V) > 11'(H_ACTIVE);

    pong_paddle_ctrl #(
        .V_ACTIVE(V_ACTIVE), .WALL_T(WALL_T), .PAD_H(PAD_H), .PAD_V(PAD_V)
    ) u_pad (
        .clk(clk), .reset_n(reset_n), .tick(tick),
        .btn_up(btn_up), .btn_dn(btn_dn), .pad_y(pad_y)
    );

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        hit_d       = mv && hit_c;
        miss_d      = mv && miss_c;
        if (tick && state_q == SERVE) begin
            serve_cnt_d = (serve_cnt_q == SERVE_LAST) ? '0 : serve_cnt_q + CW'(1);
            state_d     = (serve_cnt_q == SERVE_LAST) ? PLAY : SERVE;
        end
        if (mv) begin
            ball_y_d = top_c ? Y_MIN : bot_c ? Y_MAX : dir_y_q ? ball_y_q + V : ball_y_q - V;
            dir_y_d  = top_c ? 1'b1 : bot_c ? 1'b0 : dir_y_q;
            ball_x_d = left_c ? X_MIN : hit_c ? X_HIT : dir_x_q ? ball_x_q + V : ball_x_q - V;
            dir_x_d  = left_c || (dir_x_q && !hit_c);
            if (miss_c) begin
                ball_x_d = BX0;
                ball_y_d = BY0;
                dir_x_d  = 1'b1;
                dir_y_d  = 1'b1;
                state_d  = SERVE;
            end
        end
    end

    assign in_lw   = px >= 11'(LWALL_L) && px <= 11'(LWALL_R);
    assign in_pad  = px >= 11'(PAD_L) && px <= 11'(PAD_L + PAD_W - 1)
                  && pyy >= py && pyy <= py + 11'(PAD_H - 1);
    assign in_ball = px >= bx && px <= bx + 11'(BALL_SIZE - 1)
                  && pyy >= by && pyy <= by + 11'(BALL_SIZE - 1);
    assign in_hw   = pyy < 11'(WALL_T) || pyy >= 11'(V_ACTIVE - WALL_T);

    always_comb
        rgb_d = !video_on ? 12'h000 : in_lw ? WALL_RGB : in_pad ? PAD_RGB
              : in_ball ? BALL_RGB : in_hw ? HWALL_RGB : BG_RGB;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rgb_q       <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            cond_q      <= 1'b0;
            ball_x_q    <= BX0;
            ball_y_q    <= BY0;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            state_q     <= SERVE;
            serve_cnt_q <= '0;
        end else begin
            rgb_q       <= rgb_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            cond_q      <= cond;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
        end

    assign rgb  = rgb_q;
    assign hit  = hit_q;
    assign miss = miss_q;
endmodule

// File: tb/tb_pong_anim_graph.sv
// tb_pong_anim_graph: frame-level model of the Pong game with an rgb scoreboard, a render
// vector table for the reset picture, and directed serve/paddle/bounce/miss/hit sequences.
module tb_pong_anim_graph;
    logic        clk = 1'b0;
    logic        reset_n, video_on, btn_up, btn_dn, hit, miss;
    logic [9:0]  pixel_x, pixel_y;
    logic [11:0] rgb;

    int n_chk = 0, n_fail = 0;
    int bx, by, dx, dy, py, st, sc;
    bit m_cond, mh, mm, seen_hit, seen_miss;
    logic [11:0] exp_q[$];

    typedef struct { int x; int y; bit v; logic [11:0] rgb; } vec_t;
    vec_t vecs[18];

    always #5 clk = ~clk;

    pong_anim_graph dut (
        .clk(clk), .reset_n(reset_n), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .btn_up(btn_up), .btn_dn(btn_dn),
        .rgb(rgb), .hit(hit), .miss(miss)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        bx = 316; by = 236; dx = 1; dy = 1; py = 204; st = 0; sc = 0; m_cond = 0;
    endtask

    function automatic logic [11:0] exp_rgb(input int x, input int y, input bit v);
        if (!v) return 12'h000;
        if (x >= 32 && x <= 35) return 12'hF00;
        if (x >= 600 && x <= 603 && y >= py && y < py + 72) return 12'h0F0;
        if (x >= bx && x < bx + 8 && y >= by && y < by + 8) return 12'h00F;
        if (y < 6 || y >= 474) return 12'h00F;
        return 12'hFF0;
    endfunction

    task automatic model_tick(input bit up, input bit dn, output bit eh, output bit em);
        int nx, ny, ndx, ndy;
        bit hc;
        eh = 0; em = 0;
        if (st == 0) begin
            if (sc == 59) begin st = 1; sc = 0; end
            else sc++;
        end else begin
            ndx = dx; ndy = dy;
            if (dy == 0 && by < 8) begin ny = 6; ndy = 1; end
            else if (dy == 1 && by + 10 > 474) begin ny = 466; ndy = 0; end
            else ny = (dy == 1) ? by + 2 : by - 2;
            hc = dx == 1 && by + 7 >= py && by <= py + 71 && bx + 9 >= 600 && bx <= 603;
            if (dx == 0 && bx < 38) begin nx = 36; ndx = 1; end
            else if (hc) begin nx = 592; ndx = 0; eh = 1; end
            else if (dx == 1 && bx + 10 > 640) begin
                em = 1; nx = 316; ny = 236; ndx = 1; ndy = 1; st = 0; sc = 0;
            end
            else nx = (dx == 1) ? bx + 2 : bx - 2;
            bx = nx; by = ny; dx = ndx; dy = ndy;
        end
        if (up && !dn) py = (py - 4 < 6) ? 6 : py - 4;
        else if (dn && !up) py = (py + 4 > 402) ? 402 : py + 4;
        if (eh) mh = 1;
        if (em) mm = 1;
    endtask

    task automatic step(input int x, input int y, input bit v, input bit up, input bit dn,
                        input logic [11:0] er);
        bit c, eh, em;
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = v; btn_up = up; btn_dn = dn;
        exp_q.push_back(er);
        c = (x == 0 && y == 480);
        eh = 0; em = 0;
        if (c && !m_cond) model_tick(up, dn, eh, em);
        m_cond = c;
        cyc();
        if (hit) seen_hit = 1;
        if (miss) seen_miss = 1;
        chk("rgb", int'(rgb), int'(exp_q.pop_front()));
        chk("hit", int'(hit), int'(eh));
        chk("miss", int'(miss), int'(em));
    endtask

    task automatic frame(input bit up, input bit dn, input int hold = 1);
        for (int i = 0; i < hold; i++) step(0, 480, 1'b0, up, dn, 12'h000);
        step(1, 0, 1'b0, up, dn, 12'h000);
    endtask

    task automatic check_state();
        chk("ball_x", int'(dut.ball_x_q), bx);
        chk("ball_y", int'(dut.ball_y_q), by);
        chk("dir_x", int'(dut.dir_x_q), dx);
        chk("dir_y", int'(dut.dir_y_q), dy);
        chk("pad_y", int'(dut.pad_y), py);
        chk("state", int'(dut.state_q), st);
    endtask

    task automatic probe();
        int xs[10], ys[10];
        xs = '{bx, bx + 7, bx + 8, bx - 1, 600, 603, 601, 34, 100, 100};
        ys = '{by, by + 7, by, by + 3, py, py + 71, py + 72, 240, 3, 200};
        for (int i = 0; i < 10; i++) step(xs[i], ys[i], 1'b1, 1'b0, 1'b0, exp_rgb(xs[i], ys[i], 1'b1));
    endtask

    task automatic run_table();
        for (int i = 0; i < 18; i++) step(vecs[i].x, vecs[i].y, vecs[i].v, 1'b0, 1'b0, vecs[i].rgb);
    endtask

    initial begin
        int f;
        bit up, dn;
        vecs = '{
            '{0, 0, 1'b0, 12'h000},   '{33, 100, 1'b1, 12'hF00}, '{35, 0, 1'b1, 12'hF00},
            '{36, 100, 1'b1, 12'hFF0}, '{600, 204, 1'b1, 12'h0F0}, '{603, 275, 1'b1, 12'h0F0},
            '{601, 276, 1'b1, 12'hFF0}, '{601, 203, 1'b1, 12'hFF0}, '{316, 236, 1'b1, 12'h00F},
            '{323, 243, 1'b1, 12'h00F}, '{324, 240, 1'b1, 12'hFF0}, '{320, 5, 1'b1, 12'h00F},
            '{320, 6, 1'b1, 12'hFF0},  '{320, 474, 1'b1, 12'h00F}, '{320, 473, 1'b1, 12'hFF0},
            '{315, 236, 1'b1, 12'hFF0}, '{316, 244, 1'b1, 12'hFF0}, '{600, 0, 1'b1, 12'h00F}
        };
        reset_n = 1'b0; pixel_x = 10'd1; pixel_y = 10'd0; video_on = 1'b0;
        btn_up = 1'b0; btn_dn = 1'b0;
        model_reset();
        repeat (3) cyc();
        chk("rst_rgb", int'(rgb), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_miss", int'(miss), 0);
        reset_n = 1'b1;
        check_state();
        run_table();

        // serve hold, then first move
        repeat (59) frame(1'b0, 1'b0);
        chk("serve_hold", int'(dut.state_q), 0);
        frame(1'b0, 1'b0);
        chk("serve_done", int'(dut.state_q), 1);
        chk("serve_x", int'(dut.ball_x_q), 316);
        frame(1'b0, 1'b0);
        chk("first_x", int'(dut.ball_x_q), 318);
        chk("first_y", int'(dut.ball_y_q), 238);
        check_state();
        probe();

        // held tick coordinates give one tick only
        frame(1'b0, 1'b0, 4);
        chk("hold4_x", int'(dut.ball_x_q), 320);
        chk("hold4_y", int'(dut.ball_y_q), 240);

        // paddle up to the clamp, then both buttons
        for (int k = 1; k <= 60; k++) begin
            frame(1'b1, 1'b0);
            chk("pad_up", int'(dut.pad_y), (204 - 4 * k < 6) ? 6 : 204 - 4 * k);
        end
        frame(1'b1, 1'b1);
        chk("pad_both", int'(dut.pad_y), 6);
        check_state();
        probe();

        // free run with parked paddle until the ball is missed
        mm = 0; seen_miss = 0; f = 0;
        do begin
            frame(1'b0, 1'b0);
            chk("ball_y_hi", int'(dut.ball_y_q <= 10'd466), 1);
            chk("ball_y_lo", int'(dut.ball_y_q >= 10'd6), 1);
            check_state();
            if (f % 25 == 0) probe();
            f++;
        end while (!mm && f < 400);
        chk("miss_seen", int'(seen_miss), 1);
        chk("miss_x", int'(dut.ball_x_q), 316);
        chk("miss_y", int'(dut.ball_y_q), 236);
        repeat (59) frame(1'b0, 1'b0);
        chk("reserve_hold", int'(dut.state_q), 0);
        chk("reserve_x", int'(dut.ball_x_q), 316);
        frame(1'b0, 1'b0);
        chk("reserve_done", int'(dut.state_q), 1);

        // paddle tracks the ball: hit, then travel back to the left wall
        mh = 0; seen_hit = 0; seen_miss = 0; f = 0;
        do begin
            up = (py + 36 > by + 6);
            dn = (py + 36 < by + 2);
            frame(up, dn);
            check_state();
            f++;
        end while (!mh && f < 400);
        chk("hit_seen", int'(seen_hit), 1);
        chk("hit_x", int'(dut.ball_x_q), 592);
        chk("hit_dir", int'(dut.dir_x_q), 0);
        probe();
        f = 0;
        do begin
            up = (py + 36 > by + 6);
            dn = (py + 36 < by + 2);
            frame(up, dn);
            check_state();
            f++;
        end while (dx == 0 && f < 400);
        chk("lwall_x", int'(dut.ball_x_q), 36);
        chk("lwall_dir", int'(dut.dir_x_q), 1);
        chk("no_miss", int'(seen_miss), 0);

        // asynchronous reset in the middle of a line
        step(200, 200, 1'b1, 1'b0, 1'b0, exp_rgb(200, 200, 1'b1));
        #1 reset_n = 1'b0;
        #1;
        chk("async_rgb", int'(rgb), 0);
        chk("async_hit", int'(hit), 0);
        chk("async_miss", int'(miss), 0);
        chk("async_x", int'(dut.ball_x_q), 316);
        chk("async_y", int'(dut.ball_y_q), 236);
        chk("async_pad", int'(dut.pad_y), 204);
        chk("async_state", int'(dut.state_q), 0);
        pixel_x = 10'd1; pixel_y = 10'd0; video_on = 1'b0;
        cyc();
        model_reset();
        reset_n = 1'b1;
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
